// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stage registers
//   stage_state_e : occupancy of an elastic stage (empty / main only / main+skid)
//   NOP_INSTR     : bubble payload injected on flush or when a stage is empty
package pipe_pkg;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} stage_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at its maximum value
//   clk_i, rst_i : clock, asynchronous active-high reset (clears to 0)
//   inc_i        : count this cycle
//   cnt_o        : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_q + W'(inc_i & ~&cnt_q);

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline register with skid buffer, flush and perf counters
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   : upstream handshake; in_ready_o is registered
//   in_data_i               : upstream payload
//   stall_i                 : hold the output entry
//   flush_i                 : flush requests, any bit empties the stage
//   out_valid_o/out_ready_i : downstream handshake
//   out_data_o              : output payload, NOP_VALUE when not valid
//   stall_cnt_o/flush_cnt_o : saturating held-cycle and discarding-flush counters
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE  = DATA_W'(NOP_INSTR),
    parameter int                FLUSH_SRCS = 2,
    parameter int                CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic                  stall_i,
    input  logic [FLUSH_SRCS-1:0] flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    stage_state_e      state_q;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              out_valid_q, in_ready_q;
    logic              acc, fire, fl;

    assign acc  = in_valid_i & in_ready_q;
    assign fire = out_valid_q & out_ready_i & ~stall_i;
    assign fl   = |flush_i;

    // main_q is forced to NOP_VALUE whenever the stage goes empty, so it can
    // drive out_data_o directly without an output mux.
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (fl) begin
            state_q     <= ST_EMPTY;
            main_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY:
                    if (acc) begin
                        state_q     <= ST_ONE;
                        main_q      <= in_data_i;
                        out_valid_q <= 1'b1;
                    end
                ST_ONE:
                    if (acc && fire) main_q <= in_data_i;
                    else if (acc) begin
                        state_q    <= ST_FULL;
                        skid_q     <= in_data_i;
                        in_ready_q <= 1'b0;
                    end else if (fire) begin
                        state_q     <= ST_EMPTY;
                        main_q      <= NOP_VALUE;
                        out_valid_q <= 1'b0;
                    end
                ST_FULL:
                    if (fire) begin
                        state_q    <= ST_ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                default: begin
                    state_q     <= ST_EMPTY;
                    main_q      <= NOP_VALUE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end

    // A valid skid implies a valid main, so out_valid_q alone tells whether
    // a flush discards anything.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (reset_i),
        .inc_i (out_valid_q & ~fire),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (reset_i),
        .inc_i (fl & out_valid_q),
        .cnt_o (flush_cnt_o)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: randomized and directed scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic        stall_i = 1'b0;
    logic [1:0]  flush_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic [3:0]  stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] src_q[$];
    int sc = 0, fc = 0;

    pipe_stage_elastic #(.DATA_W(32), .FLUSH_SRCS(2), .CNT_W(4)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of capacity 2; a flush empties it.
    task automatic step();
        bit acc, fire, fl;
        acc  = in_valid_i && m_q.size() < 2;
        fire = m_q.size() > 0 && out_ready_i && !stall_i;
        fl   = |flush_i;
        if (m_q.size() > 0 && !fire && sc < CMAX) sc++;
        if (fl && m_q.size() > 0 && fc < CMAX) fc++;
        if (acc) void'(src_q.pop_front());
        if (fl) begin
            m_q.delete();
            sb_q.delete();
        end else begin
            if (fire) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(in_data_i);
                sb_q.push_back(in_data_i);
            end
        end
    endtask

    task automatic cycle(input bit v, input bit s, input logic [1:0] f, input bit r);
        @(posedge clk);
        #1;
        step();
        in_valid_i  = v && src_q.size() > 0;
        in_data_i   = src_q.size() > 0 ? src_q[0] : $urandom;
        stall_i     = s;
        flush_i     = f;
        out_ready_i = r;
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        stall_i     = 1'b0;
        flush_i     = '0;
        out_ready_i = 1'b0;
        #2;
        m_q.delete();
        sb_q.delete();
        src_q.delete();
        sc = 0;
        fc = 0;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out_data", out_data_o, 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Monitor: mid-cycle, compare visible state with the model and pop the
    // scoreboard whenever the DUT hands an entry downstream.
    initial forever begin
        @(negedge clk);
        if (!reset_i) begin
            chk("out_valid", 32'(out_valid_o), 32'(m_q.size() > 0));
            chk("in_ready", 32'(in_ready_o), 32'(m_q.size() < 2));
            chk("out_data", out_data_o, m_q.size() > 0 ? m_q[0] : 32'h0);
            chk("stall_cnt", 32'(stall_cnt_o), 32'(sc));
            chk("flush_cnt", 32'(flush_cnt_o), 32'(fc));
            if (out_valid_o && out_ready_i && !stall_i) begin
                if (sb_q.size() == 0) chk("sb_underflow", out_data_o, 32'hDEADBEEF);
                else chk("sb_order", out_data_o, sb_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] a [5] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        bit [1:0] rpat [8] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        @(posedge clk);
        #1;
        do_reset();
        src_q.push_back(32'hE3A01005);
        repeat (3) cycle(1, 0, 2'b00, 1);
        foreach (a[i]) src_q.push_back(a[i]);
        foreach (rpat[i]) cycle(1, 0, 2'b00, rpat[i][0]);
        repeat (2) cycle(0, 0, 2'b00, 1);
        src_q.push_back(32'hB1); src_q.push_back(32'hB2);
        repeat (3) cycle(1, 0, 2'b00, 0);
        repeat (3) cycle(0, 1, 2'b00, 1);
        repeat (3) cycle(0, 0, 2'b00, 1);
        src_q.push_back(32'hC1); src_q.push_back(32'hC2); src_q.push_back(32'hC3);
        repeat (3) cycle(1, 0, 2'b00, 0);
        cycle(1, 1, 2'b10, 1);
        repeat (2) cycle(0, 0, 2'b00, 1);
        src_q.delete();
        cycle(1, 0, 2'b01, 1);
        src_q.push_back(32'hC4);
        cycle(1, 0, 2'b01, 1);
        repeat (2) cycle(0, 0, 2'b00, 1);
        for (int i = 0; i < 1500; i++) begin
            while (src_q.size() < 2) src_q.push_back($urandom);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                  {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0},
                  $urandom_range(0, 9) < 7);
        end
        do_reset();
        src_q.push_back(32'hD1); src_q.push_back(32'hD2);
        repeat (2) cycle(1, 0, 2'b00, 0);
        repeat (20) cycle(0, 1, 2'b00, 1);
        @(negedge clk);
        chk("stall_sat", 32'(stall_cnt_o), 32'd15);
        repeat (3) cycle(0, 0, 2'b00, 1);
        src_q.push_back(32'hE1); src_q.push_back(32'hE2);
        repeat (3) cycle(1, 0, 2'b00, 0);
        @(negedge clk);
        chk("full_before_rst", 32'(in_ready_o), 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        repeat (2) cycle(0, 0, 2'b00, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
